// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: glyphs, anode codes,
// FSM states and the digit-to-glyph decode.
package seg7_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CONV   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   // Segment order is {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] DIG0      = 7'b1000000;
   localparam logic [6:0] DIG1      = 7'b1111001;
   localparam logic [6:0] DIG2      = 7'b0100100;
   localparam logic [6:0] DIG3      = 7'b0110000;
   localparam logic [6:0] DIG4      = 7'b0011001;
   localparam logic [6:0] DIG5      = 7'b0010010;
   localparam logic [6:0] DIG6      = 7'b0000010;
   localparam logic [6:0] DIG7      = 7'b1111000;
   localparam logic [6:0] DIG8      = 7'b0000000;
   localparam logic [6:0] DIG9      = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN0    = 4'b1110;
   localparam logic [3:0] AN1    = 4'b1101;
   localparam logic [3:0] AN2    = 4'b1011;
   localparam logic [3:0] AN3    = 4'b0111;
   localparam logic [3:0] AN_OFF = 4'b1111;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    return DIG0;
         4'd1:    return DIG1;
         4'd2:    return DIG2;
         4'd3:    return DIG3;
         4'd4:    return DIG4;
         4'd5:    return DIG5;
         4'd6:    return DIG6;
         4'd7:    return DIG7;
         4'd8:    return DIG8;
         4'd9:    return DIG9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/seg7_bin2bcd_seq.sv
// Serial double-dabble: 8-bit binary to 12-bit BCD, one shift step per clock.
// start loads the operand; done is high during the cycle of the eighth step.
module seg7_bin2bcd_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  bin,
   output logic        done,
   output logic [11:0] bcd
);

   logic [7:0]  bin_q;
   logic [11:0] bcd_q;
   logic [2:0]  step;
   logic        run;
   logic [11:0] adj;
   logic [19:0] shifted;

   function automatic logic [3:0] dd_adj(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   always_comb begin
      adj     = {dd_adj(bcd_q[11:8]), dd_adj(bcd_q[7:4]), dd_adj(bcd_q[3:0])};
      shifted = {adj, bin_q} << 1;
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q <= '0;
         bcd_q <= '0;
         step  <= '0;
         run   <= 1'b0;
      end else if (start) begin
         bin_q <= bin;
         bcd_q <= '0;
         step  <= '0;
         run   <= 1'b1;
      end else if (run) begin
         bcd_q <= shifted[19:8];
         bin_q <= shifted[7:0];
         step  <= step + 3'd1;
         if (step == 3'd7) run <= 1'b0;
      end
   end

   assign done = run && (step == 3'd7);
   assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit 7-segment controller: accepts a byte, converts it to BCD serially,
// commits all digits in one edge and time-multiplexes the anodes.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int         REFRESH_DIV = 100000,
   parameter logic [6:0] SUFFIX_SEG  = 7'b1000110
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       blank_lz,
   output logic       busy,
   output logic [3:0] an,
   output logic [6:0] seg
);

   localparam int              PW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_MAX = PW'(REFRESH_DIV - 1);

   state_t        state, next_state;
   logic          start, conv_done;
   logic [11:0]   bcd;
   logic [3:0]    hund, tens, ones;
   logic [PW-1:0] presc;
   logic [1:0]    idx;
   logic          wrap, upd;
   logic [3:0]    slot_an;
   logic [6:0]    slot_seg;

   assign start = in_valid && in_ready;

   seg7_bin2bcd_seq u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .bin   (in_data),
      .done  (conv_done),
      .bcd   (bcd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (start)     next_state = S_CONV;
         S_CONV:   if (conv_done) next_state = S_COMMIT;
         S_COMMIT:                next_state = S_IDLE;
         default:                 next_state = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == S_IDLE);
      busy     = !in_ready;
   end

   // NOTE: display registers are few flops, not a memory, so they take the async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hund <= '0;
         tens <= '0;
         ones <= '0;
      end else if (state == S_COMMIT) begin
         hund <= bcd[11:8];
         tens <= bcd[7:4];
         ones <= bcd[3:0];
      end
   end

   assign wrap = (presc == PRESC_MAX);

   // upd marks the cycle after an index change, when the pins are reloaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= '0;
         upd   <= 1'b0;
      end else begin
         presc <= wrap ? '0 : presc + 1'b1;
         if (wrap) idx <= idx + 2'd1;
         upd <= wrap;
      end
   end

   always_comb begin
      slot_an  = AN_OFF;
      slot_seg = SEG_BLANK;
      case (idx)
         2'd0: begin
            slot_an  = AN0;
            slot_seg = SUFFIX_SEG;
         end
         2'd1: begin
            slot_an  = AN1;
            slot_seg = glyph(ones);
         end
         2'd2: if (!(blank_lz && hund == 4'd0 && tens == 4'd0)) begin
            slot_an  = AN2;
            slot_seg = glyph(tens);
         end
         default: if (!(blank_lz && hund == 4'd0)) begin
            slot_an  = AN3;
            slot_seg = glyph(hund);
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
      end else if (upd) begin
         an  <= slot_an;
         seg <= slot_seg;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with REFRESH_DIV=4: handshake latency,
// BCD digits per slot, leading-zero blanking, async reset and scan cadence.
module tb_seg7_scan_ctrl;

   localparam logic [6:0] SUF = 7'b1000110;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_ready;
   logic       blank_lz = 1'b0;
   logic       busy;
   logic [3:0] an;
   logic [6:0] seg;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;
   logic [3:0] cap_an  [4];
   logic [6:0] cap_seg [4];

   seg7_scan_ctrl #(.REFRESH_DIV(4), .SUFFIX_SEG(SUF)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .blank_lz (blank_lz),
      .busy     (busy),
      .an       (an),
      .seg      (seg)
   );

   always #5 clk = ~clk;

   // Edges since reset release; pins reload at edges 5, 9, 13, ... showing slot ((cyc-1)/4)%4.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic accept(input logic [7:0] v, output int edge_no);
      int i;
      in_data  = v;
      in_valid = 1'b1;
      for (i = 0; i < 64 && !in_ready; i++) @(negedge clk);
      check("accept_timeout", 32'(i < 64), 32'd1);
      @(posedge clk);
      #1 edge_no = cyc;
      @(negedge clk);
   endtask

   task automatic wait_ready(output int low_cycles);
      low_cycles = 0;
      while (!in_ready && low_cycles < 64) begin
         low_cycles++;
         @(negedge clk);
      end
   endtask

   task automatic capture_slots();
      logic [3:0] seen;
      seen = 4'b0000;
      for (int i = 0; i < 40 && seen != 4'b1111; i++) begin
         @(negedge clk);
         if (cyc >= 5 && (cyc % 4) == 1) begin
            cap_an[((cyc - 1) / 4) % 4]  = an;
            cap_seg[((cyc - 1) / 4) % 4] = seg;
            seen[((cyc - 1) / 4) % 4]    = 1'b1;
         end
      end
      check("capture_timeout", 32'(seen), 32'hF);
   endtask

   initial begin
      int n1, n2, lowc, nchg;
      logic [3:0] prev_an;
      logic [3:0] an_tbl [4];
      logic [6:0] s100   [4];
      an_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      s100   = '{SUF, 7'b1000000, 7'b1000000, 7'b1111001};

      // 1: reset state and the blank window before the first slot
      repeat (3) @(negedge clk);
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check("pre_slot_an", 32'(an), 32'hF);
         check("pre_slot_seg", 32'(seg), 32'h7F);
         check("pre_slot_ready", 32'(in_ready), 32'd1);
      end
      @(negedge clk);
      check("first_slot_an", 32'(an), 32'(4'b1101));
      check("first_slot_seg", 32'(seg), 32'(7'b1000000));

      // 2: 255, ready low for exactly 9 cycles
      accept(8'd255, n1);
      in_valid = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
      wait_ready(lowc);
      check("ready_low_cycles", 32'(lowc), 32'd9);
      capture_slots();
      check("255_an0", 32'(cap_an[0]), 32'(4'b1110));
      check("255_seg0", 32'(cap_seg[0]), 32'(7'b1000110));
      check("255_an1", 32'(cap_an[1]), 32'(4'b1101));
      check("255_seg1", 32'(cap_seg[1]), 32'(7'b0010010));
      check("255_an2", 32'(cap_an[2]), 32'(4'b1011));
      check("255_seg2", 32'(cap_seg[2]), 32'(7'b0010010));
      check("255_an3", 32'(cap_an[3]), 32'(4'b0111));
      check("255_seg3", 32'(cap_seg[3]), 32'(7'b0100100));

      // 3: 7 with leading-zero blanking
      blank_lz = 1'b1;
      accept(8'd7, n1);
      in_valid = 1'b0;
      wait_ready(lowc);
      capture_slots();
      check("7_an0", 32'(cap_an[0]), 32'(4'b1110));
      check("7_seg0", 32'(cap_seg[0]), 32'(7'b1000110));
      check("7_an1", 32'(cap_an[1]), 32'(4'b1101));
      check("7_seg1", 32'(cap_seg[1]), 32'(7'b1111000));
      check("7_an2_blank", 32'(cap_an[2]), 32'(4'b1111));
      check("7_seg2_blank", 32'(cap_seg[2]), 32'(7'b1111111));
      check("7_an3_blank", 32'(cap_an[3]), 32'(4'b1111));
      check("7_seg3_blank", 32'(cap_seg[3]), 32'(7'b1111111));

      // 4: valid held across 100 then 42; second accept right after commit
      blank_lz = 1'b0;
      accept(8'd100, n1);
      accept(8'd42, n2);
      check("back_to_back_gap", 32'(n2 - n1), 32'd10);
      for (int i = 0; i < 4; i++) begin
         if ((cyc % 4) == 1) begin
            check("100_mid_an", 32'(an), 32'(an_tbl[((cyc - 1) / 4) % 4]));
            check("100_mid_seg", 32'(seg), 32'(s100[((cyc - 1) / 4) % 4]));
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_ready(lowc);
      capture_slots();
      check("42_seg0", 32'(cap_seg[0]), 32'(7'b1000110));
      check("42_seg1", 32'(cap_seg[1]), 32'(7'b0100100));
      check("42_seg2", 32'(cap_seg[2]), 32'(7'b0011001));
      check("42_an3", 32'(cap_an[3]), 32'(4'b0111));
      check("42_seg3", 32'(cap_seg[3]), 32'(7'b1000000));

      // 5: async reset in the middle of a conversion
      accept(8'd200, n1);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midconv_rst_an", 32'(an), 32'hF);
      check("midconv_rst_seg", 32'(seg), 32'h7F);
      check("midconv_rst_ready", 32'(in_ready), 32'd1);
      check("midconv_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 6: free-running scan cadence after release, display 000
      prev_an = 4'b1111;
      nchg = 0;
      for (int i = 0; i < 24 && nchg < 5; i++) begin
         @(negedge clk);
         if (an != prev_an) begin
            check("scan_change_cycle", 32'(cyc), 32'(5 + 4 * nchg));
            check("scan_change_an", 32'(an), 32'(an_tbl[(nchg + 1) % 4]));
            if (an != 4'b1110) check("scan_zero_seg", 32'(seg), 32'(7'b1000000));
            prev_an = an;
            nchg++;
         end
      end
      check("scan_change_count", 32'(nchg), 32'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
